// File: rtl/mem_rw_bist_pkg.sv
// Shared types and data generation for the memory write/read BIST.
// MEM_RW_BIST_INV_PASS_EN adds the inverted-data second pass states.
package mem_rw_bist_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
`ifdef MEM_RW_BIST_INV_PASS_EN
    S_WRITE_INV,
    S_READ_INV,
`endif
    S_DONE
  } state_t;

  // pattern XOR as many whole copies of the address as fit; leftover MSBs stay 0
  function automatic logic [MAX_DATA_W-1:0] exp_data(
    input logic [MAX_DATA_W-1:0] pat,
    input logic [MAX_ADDR_W-1:0] a,
    input int                    dw,
    input int                    aw
  );
    logic [MAX_DATA_W-1:0] rep;
    rep = '0;
    for (int i = 0; i < MAX_DATA_W; i++)
      if (i < (dw / aw) * aw) rep[8'(i)] = a[5'(i % aw)];
    return pat ^ rep;
  endfunction

endpackage

// File: rtl/mem_rw_bist.sv
// March-style memory BIST: write exp(a) to every word, then read back and compare.
// MEM_RW_BIST_INV_PASS_EN enables a second pass with inverted data.
module mem_rw_bist
  import mem_rw_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_pattern,
  output logic              o_mem_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rw,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] exp_base;
  logic [DATA_W-1:0] exp_cur;
  logic              inv_phase;
  logic              wr_phase;
  logic              last;
  logic              mismatch;

  assign exp_base = DATA_W'(exp_data(MAX_DATA_W'(pattern), MAX_ADDR_W'(addr), DATA_W, ADDR_W));

`ifdef MEM_RW_BIST_INV_PASS_EN
  assign inv_phase = (state == S_WRITE_INV) || (state == S_READ_INV);
  assign wr_phase  = (state == S_WRITE) || (state == S_WRITE_INV);
`else
  assign inv_phase = 1'b0;
  assign wr_phase  = (state == S_WRITE);
`endif

  assign exp_cur     = inv_phase ? ~exp_base : exp_base;
  assign last        = (addr == ADDR_MAX);
  assign mismatch    = (i_mem_rdata != exp_cur);
  assign o_mem_addr  = addr;
  assign o_mem_wdata = wr_phase ? exp_cur : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      pattern     <= '0;
      o_mem_valid <= 1'b0;
      o_mem_rw    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state       <= S_WRITE;
            pattern     <= i_pattern;
            addr        <= '0;
            o_pass      <= 1'b0;
            o_fail_addr <= '0;
            o_fail_data <= '0;
            o_mem_valid <= 1'b1;
            o_mem_rw    <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        S_WRITE
`ifdef MEM_RW_BIST_INV_PASS_EN
        , S_WRITE_INV
`endif
        : begin
          addr <= addr + 1'b1;
          if (last) begin
            o_mem_rw <= 1'b0;
`ifdef MEM_RW_BIST_INV_PASS_EN
            state <= (state == S_WRITE) ? S_READ : S_READ_INV;
`else
            state <= S_READ;
`endif
          end
        end
        S_READ
`ifdef MEM_RW_BIST_INV_PASS_EN
        , S_READ_INV
`endif
        : begin
          if (mismatch) begin
            // first failure ends the test; addr returns to 0 for DONE
            state       <= S_DONE;
            addr        <= '0;
            o_fail_addr <= addr;
            o_fail_data <= i_mem_rdata;
            o_pass      <= 1'b0;
            o_mem_valid <= 1'b0;
            o_mem_rw    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
            if (last) begin
`ifdef MEM_RW_BIST_INV_PASS_EN
              if (state == S_READ) begin
                state    <= S_WRITE_INV;
                o_mem_rw <= 1'b1;
              end else
`endif
              begin
                state       <= S_DONE;
                o_pass      <= 1'b1;
                o_mem_valid <= 1'b0;
                o_busy      <= 1'b0;
                o_done      <= 1'b1;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
